// File: rtl/breakpoint_unit_if.sv
// ---------------------------------------------------------------------------
// breakpoint_unit_if
//   Bundles the operator controls, the observed fetch address and the
//   breakpoint status outputs of breakpoint_unit.
//
//   valid       raw arm switch (asynchronous)
//   sampler     raw digit-write push-button (asynchronous)
//   digit_sel   nibble index 0..7 to write
//   hex_digit   nibble value to write
//   pc          fetch word address
//   break_point stored 32-bit breakpoint value
//   hit         sticky match flag
//
//   master: drives controls and pc, observes break_point/hit (board, bench)
//   slave : breakpoint_unit side
// ---------------------------------------------------------------------------
interface breakpoint_unit_if #(
  parameter int PC_WIDTH = 30
);
  logic                valid;
  logic                sampler;
  logic [2:0]          digit_sel;
  logic [3:0]          hex_digit;
  logic [PC_WIDTH-1:0] pc;
  logic [31:0]         break_point;
  logic                hit;

  modport master (
    output valid, sampler, digit_sel, hex_digit, pc,
    input  break_point, hit
  );

  modport slave (
    input  valid, sampler, digit_sel, hex_digit, pc,
    output break_point, hit
  );
endinterface

// File: rtl/breakpoint_unit.sv
// ---------------------------------------------------------------------------
// breakpoint_unit
//   Hardware PC breakpoint for board-level debug. The operator enters a
//   32-bit value one nibble at a time (digit_sel/hex_digit + sampler button)
//   and arms it with the valid switch. While armed, a fetch word address
//   equal to the low PC_WIDTH bits of the value sets a sticky hit flag.
//   The block only observes the CPU; it never stalls it.
//
//   Ports:
//     clk    rising-edge system clock
//     reset  synchronous, active-high reset
//     bus    breakpoint_unit_if.slave (controls, pc, break_point, hit)
// ---------------------------------------------------------------------------
module breakpoint_unit #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PC_WIDTH        = 30
) (
  input  logic              clk,
  input  logic              reset,
  breakpoint_unit_if.slave  bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel 0 = valid (arm), channel 1 = sampler (write button).
  logic [1:0]       w_raw;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_acc;
  logic [CNT_W-1:0] r_cnt [2];
  logic             r_samp_prev;

  logic [31:0]      r_bp;
  logic             r_hit;

  logic             w_armed;
  logic             w_sample_pulse;
  logic             w_match;

  assign w_raw = {bus.sampler, bus.valid};

  // Two-flop synchronizer followed by a debouncer per channel. The counter
  // only advances while the synchronized level disagrees with the accepted
  // level, so any glitch back to the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_acc       <= '0;
      r_samp_prev <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1     <= w_raw;
      r_sync2     <= r_sync1;
      r_samp_prev <= r_acc[1];
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_acc[i]) begin
          if (r_cnt[i] == CNT_MAX) begin
            r_acc[i] <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Previous accepted level resets to 0, so a button held through reset
  // yields a pulse only after it is re-accepted by the debouncer.
  assign w_armed        = r_acc[0];
  assign w_sample_pulse = r_acc[1] & ~r_samp_prev;

  // Upper display-only bits of the breakpoint take no part in the compare.
  assign w_match = w_armed && (bus.pc == r_bp[PC_WIDTH-1:0]);

  // The compare sees the pre-write value; a digit written in the same cycle
  // is used from the next cycle on. Disarm has priority over a match.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bp  <= 32'h0000_0000;
      r_hit <= 1'b0;
    end else begin
      if (w_sample_pulse) begin
        r_bp[{bus.digit_sel, 2'b00} +: 4] <= bus.hex_digit;
      end
      if (!w_armed) begin
        r_hit <= 1'b0;
      end else if (w_match) begin
        r_hit <= 1'b1;
      end
    end
  end

  assign bus.break_point = r_bp;
  assign bus.hit         = r_hit;

endmodule

// File: tb/tb_breakpoint_unit.sv
// ---------------------------------------------------------------------------
// tb_breakpoint_unit
//   Directed scenarios plus randomized button/switch/pc activity. A cycle
//   reference model built from the behavioural rules (history of raw input
//   levels, accepted levels, stored value, sticky flag) is compared against
//   the outputs on every falling edge; directed checks add fixed values.
// ---------------------------------------------------------------------------
module tb_breakpoint_unit;

  localparam int DEB = 16;
  localparam int PCW = 30;

  logic clk;
  logic reset;

  breakpoint_unit_if #(.PC_WIDTH(PCW)) bif ();

  breakpoint_unit #(
    .DEBOUNCE_CYCLES (DEB),
    .PC_WIDTH        (PCW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hv/hs hold raw input levels seen at past rising edges, index 0 = newest.
  // A level reaches the debouncer two edges later; the accepted level flips
  // once DEB consecutive debouncer samples all disagree with it.
  bit          hv [0:DEB+1];
  bit          hs [0:DEB+1];
  logic [31:0] m_bp;
  bit          m_hit, m_arm, m_samp, m_samp_prev;
  bit          all_v, all_s;
  bit          model_ok = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= DEB + 1; k++) begin
        hv[k] = 1'b0;
        hs[k] = 1'b0;
      end
      m_bp        = 32'h0;
      m_hit       = 1'b0;
      m_arm       = 1'b0;
      m_samp      = 1'b0;
      m_samp_prev = 1'b0;
      model_ok    = 1'b1;
    end else begin
      if (!m_arm) m_hit = 1'b0;
      else if (bif.pc == m_bp[PCW-1:0]) m_hit = 1'b1;
      if (m_samp && !m_samp_prev) m_bp[int'(bif.digit_sel) * 4 +: 4] = bif.hex_digit;
      m_samp_prev = m_samp;
      all_v = 1'b1;
      all_s = 1'b1;
      for (int k = 1; k <= DEB; k++) begin
        if (hv[k] == m_arm)  all_v = 1'b0;
        if (hs[k] == m_samp) all_s = 1'b0;
      end
      if (all_v) m_arm  = ~m_arm;
      if (all_s) m_samp = ~m_samp;
      for (int k = DEB + 1; k > 0; k--) begin
        hv[k] = hv[k-1];
        hs[k] = hs[k-1];
      end
      hv[0] = bif.valid;
      hs[0] = bif.sampler;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("model_bp", bif.break_point, m_bp);
      check("model_hit", {31'b0, bif.hit}, {31'b0, m_hit});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] sel, input logic [3:0] val);
    bif.digit_sel = sel;
    bif.hex_digit = val;
    bif.sampler   = 1'b1;
    cyc(40);
    bif.sampler   = 1'b0;
    cyc(40);
  endtask

  task automatic set_bp(input logic [31:0] v);
    for (int i = 0; i < 8; i++) press(3'(i), v[i*4 +: 4]);
  endtask

  task automatic step_pc(input logic [PCW-1:0] p);
    bif.pc = p;
    cyc(1);
  endtask

  int r;

  initial begin
    reset         = 1'b1;
    bif.valid     = 1'($urandom);
    bif.sampler   = 1'($urandom);
    bif.digit_sel = 3'($urandom);
    bif.hex_digit = 4'($urandom);
    bif.pc        = PCW'($urandom);

    // Reset with random inputs.
    cyc(1);
    check("rst_bp_during", bif.break_point, 32'h0);
    check("rst_hit_during", {31'b0, bif.hit}, 32'h0);
    cyc(2);
    reset       = 1'b0;
    bif.valid   = 1'b0;
    bif.sampler = 1'b0;
    bif.pc      = '0;
    cyc(1);
    check("rst_bp_after", bif.break_point, 32'h0);
    check("rst_hit_after", {31'b0, bif.hit}, 32'h0);
    cyc(24);

    // Digit entry.
    for (int i = 0; i < 8; i++) press(3'(i), 4'(i + 1));
    check("entry_bp", bif.break_point, 32'h8765_4321);

    // Bounce rejection then a clean hold.
    bif.digit_sel = 3'd0;
    bif.hex_digit = 4'hA;
    for (int i = 0; i < 12; i++) begin
      bif.sampler = ~bif.sampler;
      cyc(5);
    end
    check("bounce_none", bif.break_point, 32'h8765_4321);
    bif.sampler = 1'b1;
    cyc(17);
    check("bounce_early", bif.break_point, 32'h8765_4321);
    cyc(2);
    check("bounce_write", bif.break_point, 32'h8765_432A);
    cyc(30);
    bif.sampler = 1'b0;
    cyc(40);
    check("bounce_once", bif.break_point, 32'h8765_432A);

    // No-arm: same pc walk with valid low.
    set_bp(32'h0000_0040);
    step_pc(30'h3E); step_pc(30'h3F); step_pc(30'h40); step_pc(30'h41);
    check("noarm_hit", {31'b0, bif.hit}, 32'h0);

    // Match while armed.
    bif.pc    = 30'h0;
    bif.valid = 1'b1;
    cyc(25);
    step_pc(30'h3E); check("match_3e", {31'b0, bif.hit}, 32'h0);
    step_pc(30'h3F); check("match_3f", {31'b0, bif.hit}, 32'h0);
    step_pc(30'h40); check("match_40", {31'b0, bif.hit}, 32'h1);
    step_pc(30'h41); check("match_41", {31'b0, bif.hit}, 32'h1);

    // Disarm clears the sticky flag after the debounce path.
    bif.valid = 1'b0;
    cyc(17);
    check("disarm_early", {31'b0, bif.hit}, 32'h1);
    cyc(2);
    check("disarm_clear", {31'b0, bif.hit}, 32'h0);
    cyc(10);

    // Upper display bits ignored by the compare.
    set_bp(32'hC000_0040);
    bif.pc    = 30'h40;
    bif.valid = 1'b1;
    cyc(25);
    check("upper_hit", {31'b0, bif.hit}, 32'h1);
    bif.valid = 1'b0;
    cyc(25);
    set_bp(32'h0000_0041);
    bif.valid = 1'b1;
    cyc(25);
    check("upper_miss", {31'b0, bif.hit}, 32'h0);
    check("upper_bp", bif.break_point, 32'h0000_0041);

    // Randomized activity, including mid-operation resets.
    for (int it = 0; it < 400; it++) begin
      r = int'($urandom_range(0, 99));
      reset = (r < 4);
      if (r >= 4 && r < 28) bif.sampler = ~bif.sampler;
      if (r >= 28 && r < 38) bif.valid = ~bif.valid;
      if (r >= 38 && r < 60) begin
        bif.digit_sel = 3'($urandom);
        bif.hex_digit = 4'($urandom);
      end
      if ($urandom_range(0, 1) == 1) bif.pc = m_bp[PCW-1:0];
      else bif.pc = m_bp[PCW-1:0] + PCW'($urandom_range(0, 3)) - PCW'(1);
      cyc(int'($urandom_range(1, 25)));
    end
    reset = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
